alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Packet-level controller for the shared ALU datapath. It parses framed UART command packets (sync, function, operand A, operand B, checksum) from the UART receiver and validates the checksum. On a valid frame it loads the ALU operand/function registers, waits one cycle for the combinational ALU, captures the result, and returns a 3-byte response frame through the UART transmitter handshake. It sits between the UART RX/TX and the ALU, one level above the byte-level control unit.

Parameters:
SYNC_BYTE, 8'hA5, command frame start byte
RESP_BYTE, 8'h5A, response frame start byte
TIMEOUT_CYCLES, 50000, max idle clocks between bytes inside a frame before abort (>=2)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous reset, active-high
rx_data  input  8  received byte, valid when rx_complete=1
rx_complete  input  1  1-cycle pulse, byte received
rx_error  input  1  1-cycle pulse, framing/parity error on current byte
tx_busy  input  1  transmitter busy; rises the cycle after an accepted tx_en, falls when byte done
alu_result  input  8  combinational ALU output
txd  output  8  byte to transmit, valid while tx_en=1
tx_en  output  1  1-cycle transmit strobe
a_reg  output  8  ALU operand A
b_reg  output  8  ALU operand B
f_reg  output  4  ALU function select
busy  output  1  high in every state except IDLE
frame_done  output  1  1-cycle pulse when last response byte is strobed

Behaviour:
- Reset (async, immediate): state IDLE; txd=0, tx_en=0, a_reg=0, b_reg=0, f_reg=0, busy=0, frame_done=0; internal result/status/checksum/timeout counter cleared. Reset mid-frame or mid-TX aborts with no further tx_en.
- States: IDLE, GET_F, GET_A, GET_B, GET_CS, EXEC, TX_HDR, TX_RES, TX_STS, TX_WAIT.
- IDLE: rx_complete with rx_data==SYNC_BYTE -> GET_F; any other byte or rx_error ignored.
- GET_F/GET_A/GET_B: on rx_complete capture byte into shadow register, advance. Function byte: low nibble used, high nibble ignored but included in checksum.
- GET_CS: checksum = func_byte ^ A ^ B (full 8 bits). Match -> load a_reg/b_reg/f_reg from shadows at that edge, -> EXEC. Mismatch -> status=8'h01, result=8'h00, operand regs unchanged, -> TX_HDR.
- rx_error in any GET_* state: abort frame, status=8'h02, result=8'h00, -> TX_HDR. rx_error and rx_complete in same cycle: error wins.
- Timeout: counter clears on every byte and on entry to GET_F; if it reaches TIMEOUT_CYCLES in a GET_* state: status=8'h04, result=8'h00, -> TX_HDR.
- EXEC: exactly 1 cycle; at its closing edge capture alu_result, status=8'h00, -> TX_HDR.
- Latency: checksum byte rx_complete at edge N -> earliest tx_en high in cycle N+2 (when tx_busy=0).
- TX_HDR/TX_RES/TX_STS: when tx_busy=0 drive txd (RESP_BYTE / result / status) and tx_en=1 for one cycle, then -> TX_WAIT. While tx_busy=1, hold state, tx_en=0.
- TX_WAIT: ignore tx_busy for first cycle (guard), then wait tx_busy=0; return to next TX state; after status byte -> IDLE with frame_done=1 in the tx_en cycle of the status byte.
- Bytes/rx_error arriving during EXEC/TX_*: dropped; no queueing.
- txd holds last driven value between strobes; a_reg/b_reg/f_reg hold until next valid frame.

Test Plan:
- Valid frame A5,03,10,20,33 with alu_result stub=8'h3C -> a_reg=10,b_reg=20,f_reg=3 at edge of CS byte; tx bytes 5A,3C,00; frame_done once; tx_en first high 2 cycles after CS byte.
- Bad checksum A5,03,10,20,34 -> a/b/f unchanged from prior values; tx bytes 5A,00,01.
- rx_error pulsed coincident with rx_complete on operand A -> abort; tx 5A,00,02; then new valid frame processed normally.
- Timeout (TIMEOUT_CYCLES=20): A5,03 then silence -> at 20 idle cycles tx 5A,00,04; back to IDLE, busy=0.
- tx_busy held high 100 cycles after each strobe -> exactly 3 tx_en pulses, each only when tx_busy=0; bytes 5A,result,status in order; bytes received during TX ignored.
- Junk 00,FF,5A in IDLE -> no response, busy stays 0; assert rst mid-TX_RES -> tx_en=0 and all outputs 0 immediately, no further transmission.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: packet-level controller between the UART and the ALU.
// Parses SYNC,F,A,B,CS command frames, runs the ALU for one cycle on a good
// frame and answers with a RESP,result,status frame over the TX handshake.
module alu_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] RESP_BYTE      = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_complete,
  input  logic       rx_error,
  input  logic       tx_busy,
  input  logic [7:0] alu_result,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic [7:0] a_reg,
  output logic [7:0] b_reg,
  output logic [3:0] f_reg,
  output logic       busy,
  output logic       frame_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, GET_F, GET_A, GET_B, GET_CS, EXEC, TX_HDR, TX_RES, TX_STS, TX_WAIT
  } state_t;

  state_t        state, ret_state;
  logic [7:0]    f_sh, a_sh, b_sh;
  logic [7:0]    result, status;
  logic [TW-1:0] tmo;
  logic          guard;
  logic          tmo_hit;
  logic [7:0]    csum;

  // Idle gap inside a frame reaches the limit on this cycle
  assign tmo_hit = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign csum    = f_sh ^ a_sh ^ b_sh;
  assign busy    = (state != IDLE);

  // Frame parser, execute step and response transmitter in one FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      txd        <= '0;
      tx_en      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      f_reg      <= '0;
      frame_done <= 1'b0;
      f_sh       <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      result     <= '0;
      status     <= '0;
      tmo        <= '0;
      guard      <= 1'b0;
    end else begin
      tx_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_complete && !rx_error && rx_data == SYNC_BYTE) begin
            state <= GET_F;
            tmo   <= '0;
          end
        end
        GET_F, GET_A, GET_B, GET_CS: begin
          // A line error on the current byte outranks its completion
          if (rx_error) begin
            status <= 8'h02;
            result <= 8'h00;
            tmo    <= '0;
            state  <= TX_HDR;
          end else if (rx_complete) begin
            tmo <= '0;
            case (state)
              GET_F: begin f_sh <= rx_data; state <= GET_A; end
              GET_A: begin a_sh <= rx_data; state <= GET_B; end
              GET_B: begin b_sh <= rx_data; state <= GET_CS; end
              default: begin
                if (rx_data == csum) begin
                  a_reg <= a_sh;
                  b_reg <= b_sh;
                  f_reg <= f_sh[3:0];
                  state <= EXEC;
                end else begin
                  status <= 8'h01;
                  result <= 8'h00;
                  state  <= TX_HDR;
                end
              end
            endcase
          end else if (tmo_hit) begin
            status <= 8'h04;
            result <= 8'h00;
            tmo    <= '0;
            state  <= TX_HDR;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        EXEC: begin
          // Operands settled through the ALU during this cycle
          result <= alu_result;
          status <= 8'h00;
          state  <= TX_HDR;
        end
        TX_HDR: begin
          if (!tx_busy) begin
            txd       <= RESP_BYTE;
            tx_en     <= 1'b1;
            guard     <= 1'b1;
            ret_state <= TX_RES;
            state     <= TX_WAIT;
          end
        end
        TX_RES: begin
          if (!tx_busy) begin
            txd       <= result;
            tx_en     <= 1'b1;
            guard     <= 1'b1;
            ret_state <= TX_STS;
            state     <= TX_WAIT;
          end
        end
        TX_STS: begin
          if (!tx_busy) begin
            txd        <= status;
            tx_en      <= 1'b1;
            frame_done <= 1'b1;
            guard      <= 1'b1;
            ret_state  <= IDLE;
            state      <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // tx_busy only rises a cycle after the strobe, so skip one cycle
          if (guard) guard <= 1'b0;
          else if (!tx_busy) state <= ret_state;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a simple UART-TX busy responder.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_complete;
  logic       rx_error;
  logic       tx_busy;
  logic [7:0] alu_result;
  logic [7:0] txd;
  logic       tx_en;
  logic [7:0] a_reg, b_reg;
  logic [3:0] f_reg;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  int         hold = 3;
  int         bcnt;
  logic       busy_prev;
  logic [7:0] tx_q[$];
  int         viol = 0;
  int         fd_cnt = 0;

  alu_cmd_sequencer #(.SYNC_BYTE(8'hA5), .RESP_BYTE(8'h5A), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_complete(rx_complete),
    .rx_error(rx_error), .tx_busy(tx_busy), .alu_result(alu_result),
    .txd(txd), .tx_en(tx_en), .a_reg(a_reg), .b_reg(b_reg), .f_reg(f_reg),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after a strobe, lasts 'hold' cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_en) begin
      tx_busy <= 1'b1;
      bcnt    <= hold;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else if (bcnt == 1) begin
      bcnt    <= 0;
      tx_busy <= 1'b0;
    end
  end

  // Byte/frame monitor; busy_prev is what the DUT saw when it raised tx_en
  always @(posedge clk) begin
    busy_prev <= tx_busy;
    if (!rst && tx_en) begin
      tx_q.push_back(txd);
      if (busy_prev) viol++;
    end
    if (!rst && frame_done) fd_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_complete = 1'b1;
    @(negedge clk);
    rx_complete = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_data = '0; rx_complete = 1'b0; rx_error = 1'b0; alu_result = 8'h3C;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, tx_en, a_reg, b_reg, f_reg, busy, frame_done} !== 31'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {txd, tx_en, a_reg, b_reg, f_reg, busy, frame_done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_valid_frame;
    bit ok; int fd0;
    tx_q.delete(); fd0 = fd_cnt; alu_result = 8'h3C; hold = 3;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10); send_byte(8'h20);
    @(negedge clk);
    rx_data = 8'h33; rx_complete = 1'b1;
    @(negedge clk);                 // past edge N
    rx_complete = 1'b0;
    checks++;
    if ({a_reg, b_reg, f_reg} !== 20'h10203) begin
      errors++; $display("FAIL valid_operands: got %h want 10203", {a_reg, b_reg, f_reg});
    end
    checks++;
    if (tx_en !== 1'b0) begin errors++; $display("FAIL latency_n: tx_en got %b want 0", tx_en); end
    @(negedge clk);                 // past edge N+1
    checks++;
    if (tx_en !== 1'b0) begin errors++; $display("FAIL latency_n1: tx_en got %b want 0", tx_en); end
    @(negedge clk);                 // past edge N+2
    checks++;
    if (tx_en !== 1'b1 || txd !== 8'h5A) begin
      errors++; $display("FAIL latency_n2: tx_en %b txd %h want 1 5a", tx_en, txd);
    end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL valid_done: timed out, busy %b want 0", busy); end
    checks++;
    if (tx_q.size() != 3 || {tx_q[0], tx_q[1], tx_q[2]} !== 24'h5A3C00) begin
      errors++; $display("FAIL valid_resp: %0d bytes %h want 3 5a3c00", tx_q.size(), {tx_q[0], tx_q[1], tx_q[2]});
    end
    checks++;
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL valid_frame_done: got %0d want 1", fd_cnt - fd0); end
  endtask

  task automatic test_bad_checksum;
    bit ok;
    tx_q.delete();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h44); send_byte(8'h55); send_byte(8'h34);
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL badcs_done: timed out, busy %b want 0", busy); end
    checks++;
    if ({a_reg, b_reg, f_reg} !== 20'h10203) begin
      errors++; $display("FAIL badcs_operands: got %h want 10203", {a_reg, b_reg, f_reg});
    end
    checks++;
    if (tx_q.size() != 3 || {tx_q[0], tx_q[1], tx_q[2]} !== 24'h5A0001) begin
      errors++; $display("FAIL badcs_resp: %0d bytes %h want 3 5a0001", tx_q.size(), {tx_q[0], tx_q[1], tx_q[2]});
    end
  endtask

  task automatic test_rx_error;
    bit ok;
    tx_q.delete();
    send_byte(8'hA5); send_byte(8'h03);
    @(negedge clk);
    rx_data = 8'h10; rx_complete = 1'b1; rx_error = 1'b1;
    @(negedge clk);
    rx_complete = 1'b0; rx_error = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (!ok || tx_q.size() != 3 || {tx_q[0], tx_q[1], tx_q[2]} !== 24'h5A0002) begin
      errors++; $display("FAIL rxerr_resp: ok %b %0d bytes %h want 3 5a0002", ok, tx_q.size(), {tx_q[0], tx_q[1], tx_q[2]});
    end
    // Follow-up frame; function high nibble is ignored but checksummed
    tx_q.delete(); alu_result = 8'h7E;
    send_byte(8'hA5); send_byte(8'h95); send_byte(8'h11); send_byte(8'h22); send_byte(8'hA6);
    wait_idle(200, ok);
    checks++;
    if ({a_reg, b_reg, f_reg} !== 20'h11225) begin
      errors++; $display("FAIL rxerr_next_operands: got %h want 11225", {a_reg, b_reg, f_reg});
    end
    checks++;
    if (!ok || tx_q.size() != 3 || {tx_q[0], tx_q[1], tx_q[2]} !== 24'h5A7E00) begin
      errors++; $display("FAIL rxerr_next_resp: ok %b %0d bytes %h want 3 5a7e00", ok, tx_q.size(), {tx_q[0], tx_q[1], tx_q[2]});
    end
  endtask

  task automatic test_timeout;
    bit ok;
    tx_q.delete();
    send_byte(8'hA5); send_byte(8'h03);
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx_q.size() != 0) begin
      errors++; $display("FAIL timeout_early: busy %b bytes %0d want 1 0", busy, tx_q.size());
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || tx_q.size() != 3 || {tx_q[0], tx_q[1], tx_q[2]} !== 24'h5A0004) begin
      errors++; $display("FAIL timeout_resp: ok %b %0d bytes %h want 3 5a0004", ok, tx_q.size(), {tx_q[0], tx_q[1], tx_q[2]});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy %b want 0", busy); end
  endtask

  task automatic test_busy_hold;
    bit ok; int fd0;
    tx_q.delete(); fd0 = fd_cnt; hold = 100; viol = 0; alu_result = 8'hC3;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hFD);
    repeat (20) @(negedge clk);
    send_byte(8'hA5); send_byte(8'h01);   // dropped while transmitting
    wait_idle(1000, ok);
    checks++;
    if (!ok || tx_q.size() != 3 || {tx_q[0], tx_q[1], tx_q[2]} !== 24'h5AC300) begin
      errors++; $display("FAIL hold_resp: ok %b %0d bytes %h want 3 5ac300", ok, tx_q.size(), {tx_q[0], tx_q[1], tx_q[2]});
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL hold_strobe_busy: got %0d want 0", viol); end
    checks++;
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL hold_frame_done: got %0d want 1", fd_cnt - fd0); end
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_q.size() != 3) begin
      errors++; $display("FAIL hold_drop: busy %b bytes %0d want 0 3", busy, tx_q.size());
    end
    hold = 3;
    repeat (110) @(negedge clk);
  endtask

  task automatic test_junk_idle;
    tx_q.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_q.size() != 0) begin
      errors++; $display("FAIL junk: busy %b bytes %0d want 0 0", busy, tx_q.size());
    end
  endtask

  task automatic test_reset_mid_tx;
    bit ok;
    tx_q.delete(); alu_result = 8'h3C;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10); send_byte(8'h20); send_byte(8'h33);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_q.size() == 1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_hdr: header bytes %0d want 1", tx_q.size()); end
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({txd, tx_en, a_reg, b_reg, f_reg, busy, frame_done} !== 31'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h want 0", {txd, tx_en, a_reg, b_reg, f_reg, busy, frame_done});
    end
    @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    repeat (200) @(negedge clk);
    checks++;
    if (tx_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet: bytes %0d busy %b want 0 0", tx_q.size(), busy);
    end
  endtask

  initial begin
    test_reset;
    test_valid_frame;
    test_bad_checksum;
    test_rx_error;
    test_timeout;
    test_busy_hold;
    test_junk_idle;
    test_reset_mid_tx;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
